flu_wb_arbiter: RTL and testbench
=================================

# flu_wb_arbiter

Shares the single fixed-latency-unit (FLU) writeback port between three result sources: single-cycle units (ALU/branch/CSR), the pipelined multiplier, and the iterative divider. It tracks in-flight multiplies, holds off issue per unit class to avoid writeback collisions, and acknowledges divider results when the port is free. It sits in the execute stage, between issue and the FLU result/trans-id/exception bus to the scoreboard.

## Interface
- XLEN, 64, result width
- TRANS_ID_BITS, 3, scoreboard transaction id width
- MULT_LATENCY, 2, multiplier issue-to-result cycles, legal 1..4
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  kill all in-flight work
- issue_valid_i  in  1  an instruction is issued this cycle
- issue_class_i  in  3  flu_class_e of issued instruction
- issue_trans_id_i  in  TRANS_ID_BITS  id of issued instruction
- sc_ready_o  out  1  ALU/BRANCH/CSR issue accepted this cycle
- mult_ready_o  out  1  MULT issue accepted this cycle
- div_ready_o  out  1  DIV issue accepted this cycle
- sc_result_i  in  XLEN  single-cycle result, valid in issue cycle
- sc_ex_valid_i  in  1  single-cycle op raised exception
- mult_result_i  in  XLEN  multiplier result, valid MULT_LATENCY cycles after issue
- div_valid_i  in  1  divider holds a finished result
- div_result_i  in  XLEN  divider result
- div_ack_o  out  1  divider result consumed this cycle
- flu_valid_o  out  1  writeback valid
- flu_result_o  out  XLEN  writeback data
- flu_trans_id_o  out  TRANS_ID_BITS  writeback id
- flu_ex_valid_o  out  1  writeback carries exception

## Operation
- Issue is accepted when issue_valid_i and the ready for issue_class_i are both high; readies depend only on registered state and div_valid_i, never on issue_valid_i/issue_class_i.
- Mult tracker: MULT_LATENCY-deep shift register of {valid, trans_id}; accepted MULT enters stage 0; "mult_retire" = valid at last stage.
- sc_ready_o = !mult_retire && !div_valid_i.
- mult_ready_o = !div_valid_i (a pending divide drains the mult pipe, guaranteeing no starvation).
- div_ready_o = !div_busy && !div_valid_i; div_busy set on DIV accept, cleared on div_ack_o.
- Port selection each cycle, priority: mult_retire > accepted single-cycle issue > div_valid_i. By construction at most one of the first two occurs.
- div_ack_o = div_valid_i && !mult_retire && !(sc issue accepted). Div trans_id is captured into a register at DIV accept.
- Writeback register loads selected {result, trans_id, ex_valid}; flu_ex_valid_o is 0 for MULT and DIV.
- flush_i: clears tracker valids, div_busy, writeback valid next cycle; div_ack_o forced 0; all readies forced 0 in the flush cycle. Divider is flushed externally by the same flush_i.

## Timing
- Reset (rst_i at a clock edge): all outputs 0, tracker empty, div_busy 0; readies read 0 while rst_i high.
- Single-cycle: accepted at t -> flu_valid_o at t+1.
- MULT: accepted at t -> retire at t+MULT_LATENCY -> flu_valid_o at t+MULT_LATENCY+1; back-to-back MULT every cycle sustained.
- DIV: div_ack_o at t -> flu_valid_o at t+1; div_valid_i held until acked.
- Worst-case div wait after div_valid_i rises: MULT_LATENCY cycles.
- Reset or flush mid-operation: no writeback for any instruction accepted before it.

## Configuration
- FLU_WB_ARB_DIV_EN defined: divider path as above.
- Undefined: div_ready_o and div_ack_o tied 0, div_valid_i/div_result_i ignored, div_busy logic and div trans-id register absent; readies drop the div_valid_i term.

## Structure
- Shared package: flu_class_e {FLU_ALU, FLU_BRANCH, FLU_CSR, FLU_MULT, FLU_DIV} and struct flu_wb_t {valid, result, trans_id, ex_valid}.
- One sub-module: flu_mult_tracker (parameterized shift register, exposes retire valid and trans_id, flush clear).

## Test plan
- Reset then ALU issue id 2, sc_result 0x5 at t -> flu_valid_o=1, result 0x5, id 2 at t+1.
- MULT id 1 at t, ALU issue offered at t+2 (MULT_LATENCY=2) -> sc_ready_o=0 at t+2; flu_valid_o id 1 with mult_result at t+3.
- DIV id 4 accepted, second DIV offered -> div_ready_o=0 until ack; div_valid_i with 0xA -> div_ack_o same cycle, flu id 4 result 0xA next cycle.
- MULT every cycle, div_valid_i rises at t -> mult_ready_o=0 from t; div_ack_o no later than t+2.
- Two MULTs in flight, flush_i pulse -> no flu_valid_o for them; next ALU issue writes back normally.
- ALU with sc_ex_valid_i=1 id 3 -> flu_ex_valid_o=1, id 3 one cycle later.

Source files
------------

// File: rtl/flu_wb_arbiter_pkg.sv
// Shared types for the FLU writeback arbiter: issue classes and the writeback record.
package flu_wb_arbiter_pkg;

  localparam int unsigned FLU_XLEN     = 64;
  localparam int unsigned FLU_TID_BITS = 3;

  typedef enum logic [2:0] {
    FLU_ALU,
    FLU_BRANCH,
    FLU_CSR,
    FLU_MULT,
    FLU_DIV
  } flu_class_e;

  typedef struct packed {
    logic                    valid;
    logic [FLU_XLEN-1:0]     result;
    logic [FLU_TID_BITS-1:0] trans_id;
    logic                    ex_valid;
  } flu_wb_t;

  function automatic logic is_single_cycle(flu_class_e c);
    return (c == FLU_ALU) || (c == FLU_BRANCH) || (c == FLU_CSR);
  endfunction

endpackage

// File: rtl/flu_wb_arbiter_if.sv
// Issue handshake, result sources and FLU writeback bus of the arbiter.
interface flu_wb_arbiter_if #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic                     flush_i;
  logic                     issue_valid_i;
  logic [2:0]               issue_class_i;
  logic [TRANS_ID_BITS-1:0] issue_trans_id_i;
  logic                     sc_ready_o;
  logic                     mult_ready_o;
  logic                     div_ready_o;
  logic [XLEN-1:0]          sc_result_i;
  logic                     sc_ex_valid_i;
  logic [XLEN-1:0]          mult_result_i;
  logic                     div_valid_i;
  logic [XLEN-1:0]          div_result_i;
  logic                     div_ack_o;
  logic                     flu_valid_o;
  logic [XLEN-1:0]          flu_result_o;
  logic [TRANS_ID_BITS-1:0] flu_trans_id_o;
  logic                     flu_ex_valid_o;

  modport slave (
    input  flush_i, issue_valid_i, issue_class_i, issue_trans_id_i,
    input  sc_result_i, sc_ex_valid_i, mult_result_i, div_valid_i, div_result_i,
    output sc_ready_o, mult_ready_o, div_ready_o, div_ack_o,
    output flu_valid_o, flu_result_o, flu_trans_id_o, flu_ex_valid_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_class_i, issue_trans_id_i,
    output sc_result_i, sc_ex_valid_i, mult_result_i, div_valid_i, div_result_i,
    input  sc_ready_o, mult_ready_o, div_ready_o, div_ack_o,
    input  flu_valid_o, flu_result_o, flu_trans_id_o, flu_ex_valid_o
  );
endinterface

// File: rtl/flu_wb_arbiter_mult_tracker.sv
// Shift register of {valid, trans_id} following each multiply down its fixed-latency pipe.
module flu_mult_tracker #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TID_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [TID_W-1:0] push_id_i,
  output logic             retire_o,
  output logic [TID_W-1:0] retire_id_o
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][TID_W-1:0] id_q, id_d;

  always_comb begin
    valid_d    = '0;
    id_d       = id_q;
    valid_d[0] = push_i;
    id_d[0]    = push_id_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      id_d[i]    = id_q[i-1];
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign retire_o    = valid_q[DEPTH-1];
  assign retire_id_o = id_q[DEPTH-1];

endmodule

// File: rtl/flu_wb_arbiter.sv
// FLU writeback arbiter: multiplier retire > single-cycle issue > divider result.
// Divider path is present only when FLU_WB_ARB_DIV_EN is defined.
module flu_wb_arbiter
  import flu_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN          = FLU_XLEN,
  parameter int unsigned TRANS_ID_BITS = FLU_TID_BITS,
  parameter int unsigned MULT_LATENCY  = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  flu_wb_arbiter_if.slave bus
);

  logic                     blocked;
  logic                     div_pend;
  logic                     sc_acc;
  logic                     mult_acc;
  logic                     mult_retire;
  logic [TRANS_ID_BITS-1:0] mult_retire_id;
  flu_class_e               cls;
  flu_wb_t                  wb_q, wb_d;

  assign blocked = rst_i || bus.flush_i;
  assign cls     = flu_class_e'(bus.issue_class_i);

  flu_mult_tracker #(
    .DEPTH (MULT_LATENCY),
    .TID_W (TRANS_ID_BITS)
  ) u_mult_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (bus.flush_i),
    .push_i      (mult_acc),
    .push_id_i   (bus.issue_trans_id_i),
    .retire_o    (mult_retire),
    .retire_id_o (mult_retire_id)
  );

`ifdef FLU_WB_ARB_DIV_EN
  logic                     div_busy_q, div_busy_d;
  logic                     div_acc, div_ack;
  logic [TRANS_ID_BITS-1:0] div_id_q;

  assign div_pend        = bus.div_valid_i;
  assign bus.div_ready_o = !blocked && !div_busy_q && !bus.div_valid_i;
  assign div_acc         = bus.issue_valid_i && bus.div_ready_o && (cls == FLU_DIV);
  assign div_ack         = !blocked && bus.div_valid_i && !mult_retire && !sc_acc;
  assign bus.div_ack_o   = div_ack;

  always_comb begin
    div_busy_d = div_busy_q;
    if (div_acc)      div_busy_d = 1'b1;
    else if (div_ack) div_busy_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (blocked) div_busy_q <= 1'b0;
    else         div_busy_q <= div_busy_d;
    if (rst_i)        div_id_q <= '0;
    else if (div_acc) div_id_q <= bus.issue_trans_id_i;
  end
`else
  logic unused_div;
  assign unused_div      = ^{bus.div_valid_i, bus.div_result_i};
  assign div_pend        = 1'b0;
  assign bus.div_ready_o = 1'b0;
  assign bus.div_ack_o   = 1'b0;
`endif

  // A pending divide stalls new multiplies so the pipe drains within MULT_LATENCY cycles.
  assign bus.sc_ready_o   = !blocked && !mult_retire && !div_pend;
  assign bus.mult_ready_o = !blocked && !div_pend;
  assign sc_acc   = bus.issue_valid_i && bus.sc_ready_o && is_single_cycle(cls);
  assign mult_acc = bus.issue_valid_i && bus.mult_ready_o && (cls == FLU_MULT);

  always_comb begin
    wb_d = '0;
    if (mult_retire) begin
      wb_d.valid    = 1'b1;
      wb_d.result   = FLU_XLEN'(bus.mult_result_i);
      wb_d.trans_id = FLU_TID_BITS'(mult_retire_id);
    end else if (sc_acc) begin
      wb_d.valid    = 1'b1;
      wb_d.result   = FLU_XLEN'(bus.sc_result_i);
      wb_d.trans_id = FLU_TID_BITS'(bus.issue_trans_id_i);
      wb_d.ex_valid = bus.sc_ex_valid_i;
    end
`ifdef FLU_WB_ARB_DIV_EN
    else if (div_ack) begin
      wb_d.valid    = 1'b1;
      wb_d.result   = FLU_XLEN'(bus.div_result_i);
      wb_d.trans_id = FLU_TID_BITS'(div_id_q);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (blocked) wb_q <= '0;
    else         wb_q <= wb_d;
  end

  assign bus.flu_valid_o    = wb_q.valid;
  assign bus.flu_result_o   = XLEN'(wb_q.result);
  assign bus.flu_trans_id_o = TRANS_ID_BITS'(wb_q.trans_id);
  assign bus.flu_ex_valid_o = wb_q.ex_valid;

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Directed vector bench for flu_wb_arbiter with MULT_LATENCY = 2.
module tb_flu_wb_arbiter;
  import flu_wb_arbiter_pkg::*;

`ifdef FLU_WB_ARB_DIV_EN
  localparam logic DV_EN = 1'b1;
`else
  localparam logic DV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  flu_wb_arbiter_if #(.XLEN(64), .TRANS_ID_BITS(3)) bus ();

  flu_wb_arbiter #(.XLEN(64), .TRANS_ID_BITS(3), .MULT_LATENCY(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [2:0]  cls;
    logic [2:0]  id;
    logic [63:0] scr;
    logic        scex;
    logic [63:0] mr;
    logic        fl;
    logic        e_sc;
    logic        e_mu;
    logic        e_fv;
    logic [63:0] e_res;
    logic [2:0]  e_id;
    logic        e_ex;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic iv, input logic [2:0] cls, input logic [2:0] id,
                              input logic [63:0] scr, input logic scex, input logic [63:0] mr,
                              input logic fl, input logic e_sc, input logic e_mu,
                              input logic e_fv, input logic [63:0] e_res, input logic [2:0] e_id,
                              input logic e_ex);
    vec_t v;
    v = '{iv, cls, id, scr, scex, mr, fl, e_sc, e_mu, e_fv, e_res, e_id, e_ex};
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 2 time units later (well before the rising edge).
  task automatic cyc(input logic iv, input logic [2:0] cls, input logic [2:0] id,
                     input logic [63:0] scr, input logic scex, input logic [63:0] mr,
                     input logic dv, input logic [63:0] dres, input logic fl);
    @(negedge clk);
    bus.issue_valid_i    = iv;
    bus.issue_class_i    = cls;
    bus.issue_trans_id_i = id;
    bus.sc_result_i      = scr;
    bus.sc_ex_valid_i    = scex;
    bus.mult_result_i    = mr;
    bus.div_valid_i      = dv;
    bus.div_result_i     = dres;
    bus.flush_i          = fl;
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, FLU_ALU, 3'd0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic check_wb(input string tag, input logic fv, input logic [63:0] res,
                          input logic [2:0] id, input logic ex);
    check({tag, " flu_valid"}, {63'd0, bus.flu_valid_o}, {63'd0, fv});
    if (fv) begin
      check({tag, " flu_result"}, bus.flu_result_o, res);
      check({tag, " flu_trans_id"}, {61'd0, bus.flu_trans_id_o}, {61'd0, id});
      check({tag, " flu_ex_valid"}, {63'd0, bus.flu_ex_valid_o}, {63'd0, ex});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    //  iv  cls         id    scr      ex  mr        fl  sc  mu  fv  res      id    ex
    add(1, FLU_ALU,    3'd2, 64'h5,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  1, 64'h5,    3'd2, 0);
    add(1, FLU_MULT,   3'd1, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(1, FLU_ALU,    3'd6, 64'h77,  0, 64'hABC,  0,  0,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  1, 64'hABC,  3'd1, 0);
    add(1, FLU_CSR,    3'd3, 64'h33,  1, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  1, 64'h33,   3'd3, 1);
    add(1, FLU_MULT,   3'd5, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(1, FLU_MULT,   3'd6, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h111,  1,  0,  0,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h222,  0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(1, FLU_BRANCH, 3'd7, 64'h99,  0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  1, 64'h99,   3'd7, 0);
    add(1, FLU_MULT,   3'd1, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(1, FLU_MULT,   3'd2, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);
    add(1, FLU_MULT,   3'd3, 64'h0,   0, 64'h1001, 0,  0,  1,  0, 64'h0,    3'd0, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h1002, 0,  0,  1,  1, 64'h1001, 3'd1, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h1003, 0,  0,  1,  1, 64'h1002, 3'd2, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  1, 64'h1003, 3'd3, 0);
    add(0, FLU_ALU,    3'd0, 64'h0,   0, 64'h0,    0,  1,  1,  0, 64'h0,    3'd0, 0);

    // Reset: readies and writeback stay low while rst is asserted.
    rst = 1'b1;
    idle();
    idle();
    check("reset sc_ready", {63'd0, bus.sc_ready_o}, 64'd0);
    check("reset mult_ready", {63'd0, bus.mult_ready_o}, 64'd0);
    check("reset div_ready", {63'd0, bus.div_ready_o}, 64'd0);
    check("reset flu_valid", {63'd0, bus.flu_valid_o}, 64'd0);
    check("reset flu_result", bus.flu_result_o, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      cyc(v.iv, v.cls, v.id, v.scr, v.scex, v.mr, 1'b0, 64'd0, v.fl);
      check($sformatf("v%0d sc_ready", i), {63'd0, bus.sc_ready_o}, {63'd0, v.e_sc});
      check($sformatf("v%0d mult_ready", i), {63'd0, bus.mult_ready_o}, {63'd0, v.e_mu});
      check($sformatf("v%0d div_ready", i), {63'd0, bus.div_ready_o}, {63'd0, DV_EN && !v.fl});
      check($sformatf("v%0d div_ack", i), {63'd0, bus.div_ack_o}, 64'd0);
      check_wb($sformatf("v%0d", i), v.e_fv, v.e_res, v.e_id, v.e_ex);
    end

    // Reset while a multiply is in flight: it never writes back.
    cyc(1'b1, FLU_MULT, 3'd3, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    check("rmid mult_ready", {63'd0, bus.mult_ready_o}, 64'd1);
    rst = 1'b1;
    idle();
    check("rmid sc_ready", {63'd0, bus.sc_ready_o}, 64'd0);
    check("rmid mult_ready_rst", {63'd0, bus.mult_ready_o}, 64'd0);
    rst = 1'b0;
    cyc(1'b0, FLU_ALU, 3'd0, 64'h0, 1'b0, 64'hDEAD, 1'b0, 64'h0, 1'b0);
    check_wb("rmid c2", 1'b0, 64'h0, 3'd0, 1'b0);
    check("rmid sc_ready_after", {63'd0, bus.sc_ready_o}, 64'd1);
    idle();
    check_wb("rmid c3", 1'b0, 64'h0, 3'd0, 1'b0);

`ifdef FLU_WB_ARB_DIV_EN
    // DIV id4 accepted; second DIV refused until the result is acked.
    cyc(1'b1, FLU_DIV, 3'd4, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    check("div1 div_ready", {63'd0, bus.div_ready_o}, 64'd1);
    cyc(1'b1, FLU_DIV, 3'd5, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    check("div1 busy div_ready", {63'd0, bus.div_ready_o}, 64'd0);
    cyc(1'b0, FLU_ALU, 3'd0, 64'h0, 1'b0, 64'h0, 1'b1, 64'hA, 1'b0);
    check("div1 div_ack", {63'd0, bus.div_ack_o}, 64'd1);
    check("div1 sc_ready", {63'd0, bus.sc_ready_o}, 64'd0);
    check("div1 mult_ready", {63'd0, bus.mult_ready_o}, 64'd0);
    idle();
    check_wb("div1 wb", 1'b1, 64'hA, 3'd4, 1'b0);
    check("div1 div_ready_after", {63'd0, bus.div_ready_o}, 64'd1);

    // Continuous multiplies; divider result arrives and must be acked within 2 cycles.
    cyc(1'b1, FLU_DIV, 3'd2, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, FLU_MULT, 3'd1, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, FLU_MULT, 3'd3, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, FLU_MULT, 3'd5, 64'h0, 1'b0, 64'h51, 1'b1, 64'hD, 1'b0);
    check("div2 t mult_ready", {63'd0, bus.mult_ready_o}, 64'd0);
    check("div2 t div_ack", {63'd0, bus.div_ack_o}, 64'd0);
    cyc(1'b1, FLU_MULT, 3'd5, 64'h0, 1'b0, 64'h53, 1'b1, 64'hD, 1'b0);
    check("div2 t1 mult_ready", {63'd0, bus.mult_ready_o}, 64'd0);
    check("div2 t1 div_ack", {63'd0, bus.div_ack_o}, 64'd0);
    check_wb("div2 t1", 1'b1, 64'h51, 3'd1, 1'b0);
    cyc(1'b1, FLU_MULT, 3'd5, 64'h0, 1'b0, 64'h0, 1'b1, 64'hD, 1'b0);
    check("div2 t2 div_ack", {63'd0, bus.div_ack_o}, 64'd1);
    check_wb("div2 t2", 1'b1, 64'h53, 3'd3, 1'b0);
    idle();
    check_wb("div2 t3", 1'b1, 64'hD, 3'd2, 1'b0);
    idle();
    check_wb("div2 t4", 1'b0, 64'h0, 3'd0, 1'b0);
`else
    // Divider path absent: div inputs have no effect.
    cyc(1'b1, FLU_DIV, 3'd1, 64'h0, 1'b0, 64'h0, 1'b1, 64'hA, 1'b0);
    check("nodiv div_ready", {63'd0, bus.div_ready_o}, 64'd0);
    check("nodiv div_ack", {63'd0, bus.div_ack_o}, 64'd0);
    check("nodiv sc_ready", {63'd0, bus.sc_ready_o}, 64'd1);
    check("nodiv mult_ready", {63'd0, bus.mult_ready_o}, 64'd1);
    idle();
    check_wb("nodiv wb", 1'b0, 64'h0, 3'd0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
